// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller and its bus.
package fetch_ctrl_pkg;

  localparam int          XLEN        = 64;
  localparam logic [63:0] PC_RESET    = 64'h0000_0000_8000_0000;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs one outstanding instruction-bus
// request at a time, and drops a response made stale by an execute redirect.
module fetch_ctrl #(
  parameter int              XLEN     = fetch_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] PC_RESET = fetch_ctrl_pkg::PC_RESET
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_addr_ok,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     raw_instr,
  output logic [XLEN-1:0] pc,
  output logic            ivalid
);
  import fetch_ctrl_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     buf_q, buf_d;
  logic            drop_q, drop_d;

  ibus_resp_t      resp;
  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] pc_post;

  assign resp        = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};
  assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_next_seq = pc_q + XLEN'(INSTR_BYTES);
  assign pc_post     = redirect_valid ? redir_pc : pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      req_addr_q <= PC_RESET;
      buf_q      <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    drop_d     = drop_q;

    unique case (state_q)
      IDLE: begin
        pc_d       = pc_post;
        req_addr_d = pc_post;
        state_d    = REQ;
      end
      REQ, WAIT: begin
        if (resp.data_ok) begin
          if (!drop_q && !redirect_valid) begin
            buf_d   = resp.data;
            state_d = VALID;
          end else begin
            // Stale response: reissue at the post-redirect PC.
            drop_d     = 1'b0;
            pc_d       = pc_post;
            req_addr_d = pc_post;
            state_d    = REQ;
          end
        end else begin
          if (redirect_valid) begin
            pc_d   = redir_pc;
            drop_d = 1'b1;
          end
          if (state_q == REQ && resp.addr_ok) state_d = WAIT;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = REQ;
        end else if (!stall) begin
          pc_d       = pc_next_seq;
          req_addr_d = pc_next_seq;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ireq_valid = (state_q == REQ);
  assign ireq_addr  = req_addr_q;
  assign ivalid     = (state_q == VALID);
  assign raw_instr  = buf_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change and outputs are checked on the falling edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [31:0] raw_instr;
  logic [63:0] pc;
  logic        ivalid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_addr_ok (iresp_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .raw_instr     (raw_instr),
    .pc            (pc),
    .ivalid        (ivalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
    chk({tag, ".ireq_valid"}, 64'(ireq_valid), 64'(v));
    if (v) chk({tag, ".ireq_addr"}, ireq_addr, a);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [63:0] p,
                         input logic [31:0] r);
    chk({tag, ".ivalid"}, 64'(ivalid), 64'(v));
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".raw_instr"}, 64'(raw_instr), 64'(r));
  endtask

  task automatic bus(input logic a, input logic d, input logic [31:0] data);
    iresp_addr_ok = a;
    iresp_data_ok = d;
    iresp_data    = data;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus(1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    chk("rst.ireq_valid", 64'(ireq_valid), 64'd0);
    chk("rst.ireq_addr", ireq_addr, 64'h8000_0000);
    chk_out("rst", 1'b0, 64'h8000_0000, 32'h0);

    // Zero-wait bus: a request and its data in the same cycle.
    reset = 1'b1; bus(1'b1, 1'b1, 32'h0000_0013);
    tick(); chk_req("zw.req0", 1'b1, 64'h8000_0000); chk_out("zw.req0", 1'b0, 64'h8000_0000, 32'h0);
    tick(); chk_out("zw.val0", 1'b1, 64'h8000_0000, 32'h0000_0013); chk_req("zw.val0", 1'b0, 64'h0);
    bus(1'b1, 1'b1, 32'h0010_0093);
    tick(); chk_req("zw.req1", 1'b1, 64'h8000_0004); chk("zw.req1.ivalid", 64'(ivalid), 64'd0);
    tick(); chk_out("zw.val1", 1'b1, 64'h8000_0004, 32'h0010_0093);
    bus(1'b1, 1'b1, 32'h0000_0013);
    tick(); chk_req("zw.req2", 1'b1, 64'h8000_0008);
    tick(); chk_out("zw.val2", 1'b1, 64'h8000_0008, 32'h0000_0013);

    // Stall while VALID holds everything and issues no request.
    stall = 1'b1; bus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out("stall.hold", 1'b1, 64'h8000_0008, 32'h0000_0013);
      chk_req("stall.hold", 1'b0, 64'h0);
    end
    stall = 1'b0;
    tick(); chk_req("stall.rel", 1'b1, 64'h8000_000c);

    // Redirect during WAIT: the returning word is dropped.
    tick(); chk_req("wr.noresp", 1'b1, 64'h8000_000c);
    bus(1'b1, 1'b0, 32'h0);
    tick(); chk_req("wr.wait", 1'b0, 64'h0);
    bus(1'b0, 1'b0, 32'h0); redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick(); chk_out("wr.redir", 1'b0, 64'h8000_1000, 32'h0000_0013);
    redirect_valid = 1'b0;
    tick(); chk("wr.wait2.ivalid", 64'(ivalid), 64'd0);
    bus(1'b0, 1'b1, 32'hDEAD_BEEF);
    tick(); chk_req("wr.reissue", 1'b1, 64'h8000_1000); chk_out("wr.drop", 1'b0, 64'h8000_1000, 32'h0000_0013);
    bus(1'b1, 1'b1, 32'h0000_0517);
    tick(); chk_out("wr.val", 1'b1, 64'h8000_1000, 32'h0000_0517);

    // Redirect beats stall in VALID; low PC bits are cleared.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2002; bus(1'b0, 1'b0, 32'h0);
    tick(); chk_req("rs.req", 1'b1, 64'h8000_2000); chk_out("rs.out", 1'b0, 64'h8000_2000, 32'h0000_0517);
    stall = 1'b0;

    // Repeated redirects in REQ before acceptance: one drop, latest target wins.
    redirect_pc = 64'h8000_3000;
    tick(); chk_req("rr.hold1", 1'b1, 64'h8000_2000);
    redirect_pc = 64'h8000_4000;
    tick(); chk_req("rr.hold2", 1'b1, 64'h8000_2000); chk("rr.pc", pc, 64'h8000_4000);
    redirect_valid = 1'b0; bus(1'b1, 1'b1, 32'h1111_1111);
    tick(); chk_req("rr.reissue", 1'b1, 64'h8000_4000); chk_out("rr.drop", 1'b0, 64'h8000_4000, 32'h0000_0517);
    bus(1'b1, 1'b1, 32'h2222_2222);
    tick(); chk_out("rr.val", 1'b1, 64'h8000_4000, 32'h2222_2222);

    // Redirect coinciding with completion discards that response.
    tick(); chk_req("rc.req", 1'b1, 64'h8000_4004);
    bus(1'b1, 1'b1, 32'h3333_3333); redirect_valid = 1'b1; redirect_pc = 64'h8000_5000;
    tick(); chk_req("rc.reissue", 1'b1, 64'h8000_5000); chk_out("rc.drop", 1'b0, 64'h8000_5000, 32'h2222_2222);
    redirect_valid = 1'b0; bus(1'b1, 1'b1, 32'h4444_4444);
    tick(); chk_out("rc.val", 1'b1, 64'h8000_5000, 32'h4444_4444);

    // PC wraps silently from the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; bus(1'b1, 1'b1, 32'h5555_5555);
    tick(); chk_req("wrap.req", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    redirect_valid = 1'b0;
    tick(); chk_out("wrap.val", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5555_5555);
    bus(1'b1, 1'b1, 32'h6666_6666);
    tick(); chk_req("wrap.req0", 1'b1, 64'h0);
    tick(); chk_out("wrap.val0", 1'b1, 64'h0, 32'h6666_6666);

    // Reset from VALID, then a slow bus: addr_ok after 3 REQ cycles, data 2 cycles later.
    reset = 1'b0; bus(1'b0, 1'b0, 32'h0);
    tick(); chk_req("sl.rst", 1'b0, 64'h0); chk_out("sl.rst", 1'b0, 64'h8000_0000, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_req("sl.req", 1'b1, 64'h8000_0000);
    end
    bus(1'b1, 1'b0, 32'h0);
    tick(); chk_req("sl.wait1", 1'b0, 64'h0);
    bus(1'b0, 1'b0, 32'h0);
    tick(); chk("sl.wait2.ivalid", 64'(ivalid), 64'd0);
    bus(1'b0, 1'b1, 32'h0000_0297);
    tick(); chk_out("sl.val", 1'b1, 64'h8000_0000, 32'h0000_0297);

    // Reset during WAIT; a late data_ok for the abandoned request is ignored.
    bus(1'b0, 1'b0, 32'h0);
    tick(); chk_req("rw.req", 1'b1, 64'h8000_0004);
    bus(1'b1, 1'b0, 32'h0);
    tick(); chk_req("rw.wait", 1'b0, 64'h0);
    reset = 1'b0; bus(1'b0, 1'b0, 32'h0);
    tick(); chk_req("rw.rst", 1'b0, 64'h0); chk_out("rw.rst", 1'b0, 64'h8000_0000, 32'h0);
    reset = 1'b1; bus(1'b0, 1'b1, 32'hBADB_AD00);
    tick(); chk_req("rw.restart", 1'b1, 64'h8000_0000); chk_out("rw.restart", 1'b0, 64'h8000_0000, 32'h0);
    bus(1'b1, 1'b1, 32'h0000_0417);
    tick(); chk_out("rw.val", 1'b1, 64'h8000_0000, 32'h0000_0417);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
